// File: rtl/disp_pkg.sv
// Shared display-RAM constants: default RAM geometry, the character layout
// (GPS region followed by the speed/odometer region) and the arbiter grant
// encoding used by the write-port arbiter.
package disp_pkg;

  localparam int DISP_AW = 6;
  localparam int DISP_DW = 8;

  // GPS sentence text occupies the first 39 characters of the display RAM
  localparam logic [DISP_AW-1:0] GPS_ADDR_MIN = 6'd0;
  localparam logic [DISP_AW-1:0] GPS_ADDR_MAX = 6'd38;

  // Speed/odometer text starts right after the GPS region
  localparam logic [DISP_AW-1:0] DISP_B_BASE = 6'd39;

  // Round-robin grant / last-served encoding
  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/disp_wr_fifo.sv
// Small synchronous FIFO buffering one writer's {addr,data} entries.
// A push into a full FIFO is accepted only when a pop happens on the same
// edge; otherwise it is ignored and the caller flags the drop. No bypass:
// an entry pushed into an empty FIFO is visible on dout the cycle after.
module disp_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state pointers and occupancy; simultaneous push and pop keep the count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Pointer/count registers; reset flushes the queue
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale slots are never read while empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/disp_ram_wr_arbiter.sv
// Write-port arbiter for the 64x8 display character RAM.
// Writer A (GPS parser) and writer B (speed/odometer formatter, offset by
// B_BASE) each feed a small FIFO; the FIFOs drain round-robin, one RAM write
// per cycle, and the display scan can pause draining with hold.
// Optional feature macro: DISP_ARB_DROP_CNT_EN builds a saturating counter of
// dropped writes on drop_cnt; without it drop_cnt is constant zero.
module disp_ram_wr_arbiter
  import disp_pkg::*;
#(
  parameter int            AW     = DISP_AW,
  parameter int            DW     = DISP_DW,
  parameter int            DEPTH  = 4,
  parameter logic [AW-1:0] B_BASE = AW'(DISP_B_BASE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          a_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  input  logic          b_we,
  input  logic          hold,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_we,
  output logic          ovf_a,
  output logic          ovf_b,
  output logic          busy,
  output logic [15:0]   drop_cnt
);

  logic [AW+DW-1:0] a_dout, b_dout;
  logic             a_full, a_empty, b_full, b_empty;
  logic             a_pop, b_pop;
  logic             a_drop, b_drop;
  logic [AW-1:0]    b_addr_mapped;
  logic             last_q, last_d;
  logic [AW-1:0]    ram_addr_q, ram_addr_d;
  logic [DW-1:0]    ram_data_q, ram_data_d;
  logic             ram_we_q, ram_we_d;
  logic             ovf_a_q, ovf_a_d;
  logic             ovf_b_q, ovf_b_d;

  // B addresses wrap modulo 2^AW by design
  assign b_addr_mapped = b_addr + B_BASE;

  disp_wr_fifo #(.DEPTH(DEPTH), .W(AW+DW)) u_fifo_a (
    .clk(clk), .rst(rst), .push(a_we), .din({a_addr, a_data}),
    .pop(a_pop), .dout(a_dout), .full(a_full), .empty(a_empty)
  );

  disp_wr_fifo #(.DEPTH(DEPTH), .W(AW+DW)) u_fifo_b (
    .clk(clk), .rst(rst), .push(b_we), .din({b_addr_mapped, b_data}),
    .pop(b_pop), .dout(b_dout), .full(b_full), .empty(b_empty)
  );

  // A write is lost only when its FIFO is full and not draining this cycle
  assign a_drop = a_we && a_full && !a_pop;
  assign b_drop = b_we && b_full && !b_pop;

  // Grant selection; the pointer only moves when both writers compete
  always_comb begin
    a_pop  = 1'b0;
    b_pop  = 1'b0;
    last_d = last_q;
    if (!hold) begin
      if (!a_empty && !b_empty) begin
        if (last_q == GNT_B) begin
          a_pop  = 1'b1;
          last_d = GNT_A;
        end else begin
          b_pop  = 1'b1;
          last_d = GNT_B;
        end
      end else if (!a_empty) begin
        a_pop = 1'b1;
      end else if (!b_empty) begin
        b_pop = 1'b1;
      end
    end
  end

  // Output register next-state: load the popped entry, otherwise hold
  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_we_d   = a_pop || b_pop;
    if (a_pop) begin
      ram_addr_d = a_dout[AW+DW-1:DW];
      ram_data_d = a_dout[DW-1:0];
    end else if (b_pop) begin
      ram_addr_d = b_dout[AW+DW-1:DW];
      ram_data_d = b_dout[DW-1:0];
    end
    ovf_a_d = ovf_a_q || a_drop;
    ovf_b_d = ovf_b_q || b_drop;
  end

  // Arbiter state, RAM write register and sticky overflow flags
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= GNT_B;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_we_q   <= 1'b0;
      ovf_a_q    <= 1'b0;
      ovf_b_q    <= 1'b0;
    end else begin
      last_q     <= last_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_we_q   <= ram_we_d;
      ovf_a_q    <= ovf_a_d;
      ovf_b_q    <= ovf_b_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_we   = ram_we_q;
  assign ovf_a    = ovf_a_q;
  assign ovf_b    = ovf_b_q;
  assign busy     = !a_empty || !b_empty;

`ifdef DISP_ARB_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;

  // Both writers may drop on the same edge, so add up to two, then saturate
  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + {16'd0, a_drop} + {16'd0, b_drop};
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Dropped-write counter register
  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_disp_ram_wr_arbiter.sv
// Bench for disp_ram_wr_arbiter: directed stimulus, a queue-based model of
// the two writers' pending writes, a per-cycle compare against that model and
// literal expectations at the key points of each scenario.
module tb_disp_ram_wr_arbiter;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [5:0]  a_addr, b_addr;
  logic [7:0]  a_data, b_data;
  logic        a_we, b_we, hold;
  logic [5:0]  ram_addr;
  logic [7:0]  ram_data;
  logic        ram_we, ovf_a, ovf_b, busy;
  logic [15:0] drop_cnt;

  int compared = 0;
  int mismatched = 0;

  disp_ram_wr_arbiter dut (
    .clk(clk), .rst(rst),
    .a_addr(a_addr), .a_data(a_data), .a_we(a_we),
    .b_addr(b_addr), .b_data(b_data), .b_we(b_we),
    .hold(hold),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .ovf_a(ovf_a), .ovf_b(ovf_b), .busy(busy), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: pending writes per writer as {addr,data}, plus expected outputs
  logic [13:0] qa[$];
  logic [13:0] qb[$];
  bit          lastIsB;
  bit          modelValid = 1'b0;
  logic [5:0]  expAddr;
  logic [7:0]  expData;
  bit          expWe, expOvfA, expOvfB, expBusy;
  int          dropCount;
  int          popSide;
  logic [5:0]  mappedB;

  // Model: serve the writers from their queues, then accept or drop the new writes
  always @(posedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      lastIsB   = 1'b1;
      expAddr   = '0;
      expData   = '0;
      expWe     = 1'b0;
      expOvfA   = 1'b0;
      expOvfB   = 1'b0;
      expBusy   = 1'b0;
      dropCount = 0;
    end else begin
      popSide = 0;
      if (!hold) begin
        if (qa.size() > 0 && qb.size() > 0) begin
          popSide = lastIsB ? 1 : 2;
          lastIsB = (popSide == 2);
        end else if (qa.size() > 0) popSide = 1;
        else if (qb.size() > 0) popSide = 2;
      end
      expWe = (popSide != 0);
      if (popSide == 1) begin
        expAddr = qa[0][13:8];
        expData = qa[0][7:0];
        void'(qa.pop_front());
      end else if (popSide == 2) begin
        expAddr = qb[0][13:8];
        expData = qb[0][7:0];
        void'(qb.pop_front());
      end
      if (a_we) begin
        if (qa.size() < DEPTH) qa.push_back({a_addr, a_data});
        else begin
          expOvfA = 1'b1;
          if (dropCount < 65535) dropCount++;
        end
      end
      if (b_we) begin
        mappedB = b_addr + 6'd39;
        if (qb.size() < DEPTH) qb.push_back({mappedB, b_data});
        else begin
          expOvfB = 1'b1;
          if (dropCount < 65535) dropCount++;
        end
      end
      expBusy = (qa.size() > 0) || (qb.size() > 0);
    end
    modelValid = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] expDropCnt(input int n);
`ifdef DISP_ARB_DROP_CNT_EN
    return 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  // Compare every output against the model on the falling edge
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("model.ram_we", {15'd0, ram_we}, {15'd0, expWe});
      checkOutput("model.busy",   {15'd0, busy},   {15'd0, expBusy});
      checkOutput("model.ovf_a",  {15'd0, ovf_a},  {15'd0, expOvfA});
      checkOutput("model.ovf_b",  {15'd0, ovf_b},  {15'd0, expOvfB});
      checkOutput("model.drop_cnt", drop_cnt, expDropCnt(dropCount));
      checkOutput("model.ram_addr", {10'd0, ram_addr}, {10'd0, expAddr});
      checkOutput("model.ram_data", {8'd0, ram_data},  {8'd0, expData});
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit aWe, input logic [5:0] aAddr, input logic [7:0] aData,
                               input bit bWe, input logic [5:0] bAddr, input logic [7:0] bData);
    a_we = aWe; a_addr = aAddr; a_data = aData;
    b_we = bWe; b_addr = bAddr; b_data = bData;
    stepCycle();
    a_we = 1'b0;
    b_we = 1'b0;
  endtask

  task automatic expectWrite(input string name, input logic [5:0] addr, input logic [7:0] data);
    checkOutput({name, ".we"},   {15'd0, ram_we}, 16'd1);
    checkOutput({name, ".addr"}, {10'd0, ram_addr}, {10'd0, addr});
    checkOutput({name, ".data"}, {8'd0, ram_data},  {8'd0, data});
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0;
    a_we = 1'b0; a_addr = '0; a_data = '0;
    b_we = 1'b0; b_addr = '0; b_data = '0;
    repeat (2) stepCycle();
    checkOutput("reset.ram_we", {15'd0, ram_we}, 16'd0);
    checkOutput("reset.ram_addr", {10'd0, ram_addr}, 16'd0);
    checkOutput("reset.busy", {15'd0, busy}, 16'd0);
    checkOutput("reset.drop_cnt", drop_cnt, 16'd0);
    rst = 1'b0;
    stepCycle();

    // Single A write: pulse two edges after the strobe
    applyStimulus(1'b1, 6'd5, 8'h41, 1'b0, 6'd0, 8'h00);
    checkOutput("t1.busy", {15'd0, busy}, 16'd1);
    checkOutput("t1.early_we", {15'd0, ram_we}, 16'd0);
    stepCycle();
    expectWrite("t1", 6'd5, 8'h41);
    checkOutput("t1.busy_after", {15'd0, busy}, 16'd0);
    stepCycle();
    checkOutput("t1.we_off", {15'd0, ram_we}, 16'd0);
    checkOutput("t1.addr_held", {10'd0, ram_addr}, 16'd5);

    // Contention: A wins first, B follows on the next cycle
    applyStimulus(1'b1, 6'd3, 8'h31, 1'b1, 6'd2, 8'h39);
    stepCycle();
    expectWrite("t2a", 6'd3, 8'h31);
    stepCycle();
    expectWrite("t2b", 6'd41, 8'h39);
    stepCycle();

    // B address wraps: 30 + 39 = 69 -> 5
    applyStimulus(1'b0, 6'd0, 8'h00, 1'b1, 6'd30, 8'h58);
    stepCycle();
    expectWrite("t3", 6'd5, 8'h58);
    stepCycle();

    // Hold with five A writes: fifth dropped, four drain in order
    hold = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 6'(10 + i), 8'(8'h60 + i), 1'b0, 6'd0, 8'h00);
    checkOutput("t4.ovf_a", {15'd0, ovf_a}, 16'd1);
    checkOutput("t4.drop_cnt", drop_cnt, expDropCnt(1));
    checkOutput("t4.held_we", {15'd0, ram_we}, 16'd0);
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      expectWrite("t4.drain", 6'(10 + i), 8'(8'h60 + i));
    end
    stepCycle();
    checkOutput("t4.idle", {15'd0, ram_we}, 16'd0);

    // Full FIFO with push on the same edge as a pop: accepted
    rst = 1'b1; stepCycle(); rst = 1'b0;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 6'(20 + i), 8'(8'h70 + i), 1'b0, 6'd0, 8'h00);
    hold = 1'b0;
    applyStimulus(1'b1, 6'd24, 8'h74, 1'b0, 6'd0, 8'h00);
    expectWrite("t5.first", 6'd20, 8'h70);
    checkOutput("t5.ovf_a", {15'd0, ovf_a}, 16'd0);
    for (int i = 1; i < 5; i++) begin
      stepCycle();
      expectWrite("t5.drain", 6'(20 + i), 8'(8'h70 + i));
    end
    stepCycle();

    // Reset with queued writes discards them
    hold = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 6'(i), 8'h41, 1'b1, 6'(i), 8'h42);
    rst = 1'b1; hold = 1'b0;
    stepCycle();
    checkOutput("t6.we", {15'd0, ram_we}, 16'd0);
    checkOutput("t6.busy", {15'd0, busy}, 16'd0);
    rst = 1'b0;
    stepCycle();
    checkOutput("t6.no_stale", {15'd0, ram_we}, 16'd0);
    applyStimulus(1'b1, 6'd7, 8'h5A, 1'b0, 6'd0, 8'h00);
    stepCycle();
    expectWrite("t6.next", 6'd7, 8'h5A);
    stepCycle();

    // Both writers drop on the same edge
    hold = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 6'(i), 8'h61, 1'b1, 6'(i), 8'h62);
    checkOutput("t7.ovf_b", {15'd0, ovf_b}, 16'd1);
    checkOutput("t7.drop_cnt", drop_cnt, expDropCnt(2));
    hold = 1'b0;
    repeat (10) stepCycle();
    checkOutput("t7.drained", {15'd0, busy}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
